// File: rtl/div_bcd_out_pkg.sv
// Shared types and constants for the div_bcd_out BCD output stage.
// Optional ASCII outputs are enabled with `define DIV_BCD_ASCII_EN.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam int unsigned W_DEF  = 8;
   localparam int unsigned ND_DEF = 3;
   localparam int unsigned BCD_DW = 4;
   localparam logic [7:0]  ASCII_ZERO = 8'h30;

   // Used at elaboration to confirm ND decimal digits can hold 2^W-1.
   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/div_bcd_out_if.sv
// Handshake bundle between the divider, the BCD converter and its consumer.
// Carries q_ascii/r_ascii only when DIV_BCD_ASCII_EN is defined.
interface div_bcd_out_if import div_pkg::*; #(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned ND = ND_DEF
) ();

   logic                   in_valid;
   logic                   in_ready;
   logic [W-1:0]           in_quotient;
   logic [W-1:0]           in_remainder;
   logic                   out_valid;
   logic                   out_ready;
   logic [BCD_DW*ND-1:0]   q_bcd;
   logic [BCD_DW*ND-1:0]   r_bcd;
`ifdef DIV_BCD_ASCII_EN
   logic [8*ND-1:0]        q_ascii;
   logic [8*ND-1:0]        r_ascii;

   modport master (
      output in_valid, in_quotient, in_remainder, out_ready,
      input  in_ready, out_valid, q_bcd, r_bcd, q_ascii, r_ascii
   );

   modport slave (
      input  in_valid, in_quotient, in_remainder, out_ready,
      output in_ready, out_valid, q_bcd, r_bcd, q_ascii, r_ascii
   );
`else
   modport master (
      output in_valid, in_quotient, in_remainder, out_ready,
      input  in_ready, out_valid, q_bcd, r_bcd
   );

   modport slave (
      input  in_valid, in_quotient, in_remainder, out_ready,
      output in_ready, out_valid, q_bcd, r_bcd
   );
`endif

endinterface

// File: rtl/div_bcd_out_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// {bcd, bin} left by one. Purely combinational.
module bcd_dabble_step import div_pkg::*; #(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned ND = ND_DEF
) (
   input  logic [BCD_DW*ND-1:0] bcd_i,
   input  logic [W-1:0]         bin_i,
   output logic [BCD_DW*ND-1:0] bcd_o,
   output logic [W-1:0]         bin_o
);

   logic [BCD_DW*ND-1:0] adj;

   always_comb begin
      adj = bcd_i;
      for (int unsigned d = 0; d < ND; d++) begin
         if (bcd_i[d*BCD_DW +: BCD_DW] >= 4'd5)
            adj[d*BCD_DW +: BCD_DW] = bcd_i[d*BCD_DW +: BCD_DW] + 4'd3;
      end
   end

   // The bit shifted out of the top digit is always zero given 10^ND > 2^W-1.
   assign bcd_o = (BCD_DW*ND)'({adj, bin_i[W-1]});
   assign bin_o = {bin_i[W-2:0], 1'b0};

endmodule

// File: rtl/div_bcd_out.sv
// Accepts one quotient/remainder pair, converts both to packed BCD one bit per
// cycle, and holds the result until consumed. DIV_BCD_ASCII_EN adds ASCII copies.
module div_bcd_out import div_pkg::*; #(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned ND = ND_DEF
) (
   input  logic          clk,
   input  logic          rst,
   div_bcd_out_if.slave  bus
);

   localparam int unsigned CW = $clog2(W + 1);
   localparam int unsigned BW = BCD_DW * ND;

   if (pow10(ND) <= ((64'd1 << W) - 64'd1)) begin : g_nd_check
      $error("div_bcd_out: ND decimal digits cannot represent 2^W-1");
   end

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    qbin_q, qbin_d, rbin_q, rbin_d;
   logic [BW-1:0]   qacc_q, qacc_d, racc_q, racc_d;
   logic [BW-1:0]   q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;

   logic [BW-1:0]   q_step_bcd, r_step_bcd;
   logic [W-1:0]    q_step_bin, r_step_bin;

   bcd_dabble_step #(.W(W), .ND(ND)) u_step_q (
      .bcd_i (qacc_q),
      .bin_i (qbin_q),
      .bcd_o (q_step_bcd),
      .bin_o (q_step_bin)
   );

   bcd_dabble_step #(.W(W), .ND(ND)) u_step_r (
      .bcd_i (racc_q),
      .bin_i (rbin_q),
      .bcd_o (r_step_bcd),
      .bin_o (r_step_bin)
   );

`ifdef DIV_BCD_ASCII_EN
   logic [8*ND-1:0] q_ascii_q, q_ascii_d, r_ascii_q, r_ascii_d;
   logic [8*ND-1:0] q_ascii_nx, r_ascii_nx;

   always_comb begin
      q_ascii_nx = '0;
      r_ascii_nx = '0;
      for (int unsigned d = 0; d < ND; d++) begin
         q_ascii_nx[d*8 +: 8] = ASCII_ZERO | {4'h0, q_step_bcd[d*BCD_DW +: BCD_DW]};
         r_ascii_nx[d*8 +: 8] = ASCII_ZERO | {4'h0, r_step_bcd[d*BCD_DW +: BCD_DW]};
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qbin_d  = qbin_q;
      rbin_d  = rbin_q;
      qacc_d  = qacc_q;
      racc_d  = racc_q;
      q_bcd_d = q_bcd_q;
      r_bcd_d = r_bcd_q;
`ifdef DIV_BCD_ASCII_EN
      q_ascii_d = q_ascii_q;
      r_ascii_d = r_ascii_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               qbin_d  = bus.in_quotient;
               rbin_d  = bus.in_remainder;
               qacc_d  = '0;
               racc_d  = '0;
               cnt_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            qbin_d = q_step_bin;
            rbin_d = r_step_bin;
            qacc_d = q_step_bcd;
            racc_d = r_step_bcd;
            cnt_d  = cnt_q + CW'(1);
            // Latch straight from the step outputs so the result lands on the W-th edge.
            if (cnt_q == CW'(W - 1)) begin
               q_bcd_d = q_step_bcd;
               r_bcd_d = r_step_bcd;
`ifdef DIV_BCD_ASCII_EN
               q_ascii_d = q_ascii_nx;
               r_ascii_d = r_ascii_nx;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         qbin_q  <= '0;
         rbin_q  <= '0;
         qacc_q  <= '0;
         racc_q  <= '0;
         q_bcd_q <= '0;
         r_bcd_q <= '0;
`ifdef DIV_BCD_ASCII_EN
         q_ascii_q <= '0;
         r_ascii_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qbin_q  <= qbin_d;
         rbin_q  <= rbin_d;
         qacc_q  <= qacc_d;
         racc_q  <= racc_d;
         q_bcd_q <= q_bcd_d;
         r_bcd_q <= r_bcd_d;
`ifdef DIV_BCD_ASCII_EN
         q_ascii_q <= q_ascii_d;
         r_ascii_q <= r_ascii_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.q_bcd     = q_bcd_q;
   assign bus.r_bcd     = r_bcd_q;
`ifdef DIV_BCD_ASCII_EN
   assign bus.q_ascii   = q_ascii_q;
   assign bus.r_ascii   = r_ascii_q;
`endif

endmodule

// File: tb/tb_div_bcd_out.sv
// Self-checking bench for div_bcd_out against a decimal-arithmetic reference.
module tb_div_bcd_out;

   logic clk;
   logic rst;
   int unsigned checks;
   int unsigned errors;

   div_bcd_out_if #(.W(8), .ND(3)) bus ();

   div_bcd_out #(.W(8), .ND(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [11:0] ref_bcd(input int unsigned v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [23:0] ref_ascii(input int unsigned v);
      return {8'(48 + v / 100), 8'(48 + (v / 10) % 10), 8'(48 + v % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int unsigned lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_quotient = '0;
      bus.in_remainder = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.q_bcd !== 12'h000) begin errors++; $display("FAIL reset_q_bcd: got %h expected 000", bus.q_bcd); end
      checks++; if (bus.r_bcd !== 12'h000) begin errors++; $display("FAIL reset_r_bcd: got %h expected 000", bus.r_bcd); end
`ifdef DIV_BCD_ASCII_EN
      checks++; if (bus.q_ascii !== 24'h0) begin errors++; $display("FAIL reset_q_ascii: got %h expected 0", bus.q_ascii); end
`endif
   endtask

   task automatic test_max_value();
      int unsigned lat;
      bus.in_quotient = 8'd255;
      bus.in_remainder = 8'd0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL max_latency: got %0d expected 8", lat); end
      checks++; if (bus.q_bcd !== 12'h255) begin errors++; $display("FAIL max_q_bcd: got %h expected 255", bus.q_bcd); end
      checks++; if (bus.r_bcd !== 12'h000) begin errors++; $display("FAIL max_r_bcd: got %h expected 000", bus.r_bcd); end
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL max_release: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_div_200_by_7();
      int unsigned lat;
      bus.in_quotient = 8'd28;
      bus.in_remainder = 8'd4;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL d200_latency: got %0d expected 8", lat); end
      checks++; if (bus.q_bcd !== 12'h028) begin errors++; $display("FAIL d200_q_bcd: got %h expected 028", bus.q_bcd); end
      checks++; if (bus.r_bcd !== 12'h004) begin errors++; $display("FAIL d200_r_bcd: got %h expected 004", bus.r_bcd); end
`ifdef DIV_BCD_ASCII_EN
      checks++; if (bus.q_ascii !== 24'h303238) begin errors++; $display("FAIL d200_q_ascii: got %h expected 303238", bus.q_ascii); end
      checks++; if (bus.r_ascii !== 24'h303034) begin errors++; $display("FAIL d200_r_ascii: got %h expected 303034", bus.r_ascii); end
`endif
      tick();
   endtask

   task automatic test_backpressure();
      int unsigned lat;
      int unsigned q;
      int unsigned r;
      q = $urandom_range(0, 255);
      r = $urandom_range(0, 255);
      bus.in_quotient = 8'(q);
      bus.in_remainder = 8'(r);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", bus.out_valid); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready: got %b expected 0", bus.in_ready); end
         checks++; if (bus.q_bcd !== ref_bcd(q) || bus.r_bcd !== ref_bcd(r)) begin errors++; $display("FAIL bp_hold_data: got q=%h r=%h expected q=%h r=%h", bus.q_bcd, bus.r_bcd, ref_bcd(q), ref_bcd(r)); end
         tick();
      end
      // New pair offered on the same edge as the output handshake.
      bus.out_ready = 1'b1;
      bus.in_quotient = 8'd77;
      bus.in_remainder = 8'd123;
      bus.in_valid = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); end
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got in_ready=%b expected 0", bus.in_ready); end
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL bp2_latency: got %0d expected 8", lat); end
      checks++; if (bus.q_bcd !== 12'h077 || bus.r_bcd !== 12'h123) begin errors++; $display("FAIL bp2_data: got q=%h r=%h expected q=077 r=123", bus.q_bcd, bus.r_bcd); end
      bus.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_ignore_during_conv();
      int unsigned lat;
      int unsigned q;
      int unsigned r;
      q = $urandom_range(100, 255);
      r = $urandom_range(0, 255);
      bus.in_quotient = 8'(q);
      bus.in_remainder = 8'(r);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.in_quotient = 8'd99;
      bus.in_remainder = 8'd5;
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL ign_latency: got %0d expected 8", lat); end
      checks++; if (bus.q_bcd !== ref_bcd(q) || bus.r_bcd !== ref_bcd(r)) begin errors++; $display("FAIL ign_first_data: got q=%h r=%h expected q=%h r=%h", bus.q_bcd, bus.r_bcd, ref_bcd(q), ref_bcd(r)); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ign_idle: got in_ready=%b expected 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      wait_out(lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL ign2_latency: got %0d expected 8", lat); end
      checks++; if (bus.q_bcd !== 12'h099 || bus.r_bcd !== 12'h005) begin errors++; $display("FAIL ign2_data: got q=%h r=%h expected q=099 r=005", bus.q_bcd, bus.r_bcd); end
      bus.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_conv();
      int unsigned stale;
      bus.in_quotient = 8'($urandom_range(1, 255));
      bus.in_remainder = 8'($urandom_range(1, 255));
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.q_bcd !== 12'h000 || bus.r_bcd !== 12'h000) begin errors++; $display("FAIL rmid_data: got q=%h r=%h expected 000", bus.q_bcd, bus.r_bcd); end
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.out_valid !== 1'b0) stale++;
      end
      checks++; if (stale != 0) begin errors++; $display("FAIL rmid_stale_valid: got %0d cycles expected 0", stale); end
   endtask

   task automatic test_sweep();
      logic [11:0] exp_q[$];
      logic [11:0] exp_r[$];
      logic [11:0] eq;
      logic [11:0] er;
      int unsigned idx;
      int unsigned got;
      int unsigned cyc;
      logic fin;
      logic fout;
      idx = 0;
      got = 0;
      cyc = 0;
      bus.in_quotient = 8'(idx);
      bus.in_remainder = 8'(255 - idx);
      bus.in_valid = 1'b1;
      while (got < 256 && cyc < 256 * 40) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         #0;
         fin  = bus.in_valid && bus.in_ready;
         fout = bus.out_valid && bus.out_ready;
         if (fout) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sweep_unexpected: got q=%h r=%h expected no result", bus.q_bcd, bus.r_bcd);
            end else begin
               eq = exp_q.pop_front();
               er = exp_r.pop_front();
               if (bus.q_bcd !== eq || bus.r_bcd !== er) begin
                  errors++;
                  $display("FAIL sweep_data: got q=%h r=%h expected q=%h r=%h", bus.q_bcd, bus.r_bcd, eq, er);
               end
            end
            got++;
         end
         if (fin) begin
            exp_q.push_back(ref_bcd(idx));
            exp_r.push_back(ref_bcd(255 - idx));
         end
         tick();
         cyc++;
         if (fin) begin
            idx++;
            if (idx < 256) begin
               bus.in_quotient = 8'(idx);
               bus.in_remainder = 8'(255 - idx);
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      checks++; if (got != 256) begin errors++; $display("FAIL sweep_count: got %0d results expected 256", got); end
   endtask

`ifdef DIV_BCD_ASCII_EN
   task automatic test_ascii_random();
      int unsigned lat;
      int unsigned q;
      int unsigned r;
      q = $urandom_range(0, 255);
      r = $urandom_range(0, 255);
      bus.in_quotient = 8'(q);
      bus.in_remainder = 8'(r);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      wait_out(lat);
      checks++; if (bus.q_ascii !== ref_ascii(q) || bus.r_ascii !== ref_ascii(r)) begin errors++; $display("FAIL ascii_random: got q=%h r=%h expected q=%h r=%h", bus.q_ascii, bus.r_ascii, ref_ascii(q), ref_ascii(r)); end
      bus.out_ready = 1'b1;
      tick();
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_max_value();
      test_div_200_by_7();
      test_backpressure();
      test_ignore_during_conv();
      test_reset_mid_conv();
`ifdef DIV_BCD_ASCII_EN
      test_ascii_random();
`endif
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
